// File: rtl/uart_cmd_decoder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : uart_cmd_decoder_pkg                                       |
// | Brief   : Shared command nibbles, reply bytes and FSM encodings for  |
// |           the UART command decoder.                                  |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package uart_cmd_decoder_pkg;

  // Command nibbles carried in the Hamming(7,4) payload
  localparam logic [3:0] CMD_ON     = 4'h6;
  localparam logic [3:0] CMD_OFF    = 4'hD;
  localparam logic [3:0] CMD_TOGGLE = 4'h9;
  localparam logic [3:0] CMD_PING   = 4'h3;

  // Default reply bytes
  localparam logic [7:0] ACK_BYTE_DEFAULT = 8'h3C;
  localparam logic [7:0] NAK_BYTE_DEFAULT = 8'hC3;

  // FSM encoding
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_DECODE    = 3'd1;
  localparam state_t ST_REPLY     = 3'd2;
  localparam state_t ST_WAIT_BUSY = 3'd3;
  localparam state_t ST_WAIT_DONE = 3'd4;

  // True for the four nibbles the application understands
  function automatic logic is_known_cmd(input logic [3:0] nib);
    return (nib == CMD_ON) || (nib == CMD_OFF) ||
           (nib == CMD_TOGGLE) || (nib == CMD_PING);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hamming_7_4_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : hamming_7_4_decoder                                        |
// | Brief   : Combinational Hamming(7,4) decoder. Bit order [0..6] is    |
// |           p1,p2,d1,p3,d2,d3,d4. Single-bit correction of the data    |
// |           bits is compiled in with HAMMING_CORRECT_EN.               |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module hamming_7_4_decoder (
  input  logic [6:0] hamming_in,
  output logic [3:0] data_out,
  output logic [2:0] syndrome,
  output logic       error_detected
);

  // Syndrome is the 1-based position of a single flipped bit (0 = clean)
  always_comb begin
    syndrome = {hamming_in[3] ^ hamming_in[4] ^ hamming_in[5] ^ hamming_in[6],
                hamming_in[1] ^ hamming_in[2] ^ hamming_in[5] ^ hamming_in[6],
                hamming_in[0] ^ hamming_in[2] ^ hamming_in[4] ^ hamming_in[6]};
    error_detected = (syndrome != 3'd0);
  end

`ifdef HAMMING_CORRECT_EN
  // Flip a data bit when the syndrome points at it; parity-bit errors need no fix
  always_comb begin
    data_out = {hamming_in[6] ^ (syndrome == 3'd7),
                hamming_in[5] ^ (syndrome == 3'd6),
                hamming_in[4] ^ (syndrome == 3'd5),
                hamming_in[2] ^ (syndrome == 3'd3)};
  end
`else
  // Raw data bits; any error is left for the caller to reject
  always_comb begin
    data_out = {hamming_in[6], hamming_in[5], hamming_in[4], hamming_in[2]};
  end
`endif

endmodule
`default_nettype wire

// File: rtl/uart_cmd_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : uart_cmd_decoder                                           |
// | Brief   : Decodes Hamming(7,4) command bytes from uart_rx, strobes   |
// |           command pulses and answers ACK/NAK through uart_tx.        |
// |           Optional macro HAMMING_CORRECT_EN enables 1-bit repair.    |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module uart_cmd_decoder
  import uart_cmd_decoder_pkg::*;
#(
  parameter logic [7:0]  ACK_BYTE   = ACK_BYTE_DEFAULT,
  parameter logic [7:0]  NAK_BYTE   = NAK_BYTE_DEFAULT,
  parameter int unsigned TX_TIMEOUT = 1024,
  parameter int unsigned ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           rx_data,
  input  logic                 rx_done,
  input  logic                 rx_parity_error,
  input  logic                 tx_busy,
  output logic [7:0]           tx_data,
  output logic                 start_tx,
  output logic [3:0]           cmd_nibble,
  output logic                 cmd_valid,
  output logic                 cmd_on,
  output logic                 cmd_off,
  output logic                 cmd_toggle,
  output logic                 err_corrected,
  output logic                 err_reject,
  output logic                 overrun,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 busy
);

  localparam int unsigned      TMO_W    = $clog2(TX_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TX_TIMEOUT - 1);

  state_t                 state_q, state_d;
  logic [7:0]             rx_byte_q, rx_byte_d;
  logic                   rx_par_q, rx_par_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic [3:0]             nibble_q, nibble_d;
  logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic [3:0]             ham_nibble;
  logic [2:0]             ham_syndrome;
  logic                   ham_detected;
  logic                   hamming_err;
  logic                   syn_reject;
  logic                   corrected_hit;
  logic                   reject;
  logic                   tx_timeout;
  logic [1:0]             err_inc;
  logic [ERR_CNT_W:0]     err_sum;

  hamming_7_4_decoder u_hamming (
    .hamming_in     (rx_byte_q[6:0]),
    .data_out       (ham_nibble),
    .syndrome       (ham_syndrome),
    .error_detected (ham_detected)
  );

  assign hamming_err = ham_detected && (ham_syndrome != 3'd0);

`ifdef HAMMING_CORRECT_EN
  assign syn_reject    = 1'b0;
  assign corrected_hit = hamming_err;
`else
  assign syn_reject    = hamming_err;
  assign corrected_hit = 1'b0;
`endif

  assign reject     = rx_byte_q[7] || rx_par_q || syn_reject || !is_known_cmd(ham_nibble);
  assign tx_timeout = (state_q == ST_WAIT_BUSY) && !tx_busy && (tmo_cnt_q == TMO_LAST);

  // State and datapath registers; reset aborts any transaction at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      rx_byte_q <= 8'h00;
      rx_par_q  <= 1'b0;
      tx_data_q <= 8'h00;
      nibble_q  <= 4'h0;
      tmo_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rx_byte_q <= rx_byte_d;
      rx_par_q  <= rx_par_d;
      tx_data_q <= tx_data_d;
      nibble_q  <= nibble_d;
      tmo_cnt_q <= tmo_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Next-state and datapath updates, including the saturating error counter
  always_comb begin
    state_d   = state_q;
    rx_byte_d = rx_byte_q;
    rx_par_d  = rx_par_q;
    tx_data_d = tx_data_q;
    nibble_d  = nibble_q;
    tmo_cnt_d = tmo_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (rx_done) begin
          rx_byte_d = rx_data;
          rx_par_d  = rx_parity_error;
          state_d   = ST_DECODE;
        end
      end
      ST_DECODE: begin
        tx_data_d = reject ? NAK_BYTE : ACK_BYTE;
        nibble_d  = ham_nibble;
        state_d   = ST_REPLY;
      end
      ST_REPLY: begin
        if (!tx_busy) begin
          tmo_cnt_d = '0;
          state_d   = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (tx_timeout) begin
          state_d = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Reject, overrun and timeout can coincide, so add them together
    err_inc   = {1'b0, err_reject} + {1'b0, overrun} + {1'b0, tx_timeout};
    err_sum   = {1'b0, err_cnt_q} + {{(ERR_CNT_W-1){1'b0}}, err_inc};
    err_cnt_d = err_sum[ERR_CNT_W] ? {ERR_CNT_W{1'b1}} : err_sum[ERR_CNT_W-1:0];
  end

  // Output decode: strobes live only in DECODE, start_tx only in REPLY
  always_comb begin
    cmd_valid     = (state_q == ST_DECODE) && !reject;
    cmd_on        = cmd_valid && (ham_nibble == CMD_ON);
    cmd_off       = cmd_valid && (ham_nibble == CMD_OFF);
    cmd_toggle    = cmd_valid && (ham_nibble == CMD_TOGGLE);
    err_reject    = (state_q == ST_DECODE) && reject;
    err_corrected = (state_q == ST_DECODE) && corrected_hit;
    overrun       = rx_done && (state_q != ST_IDLE);
    start_tx      = (state_q == ST_REPLY) && !tx_busy;
    busy          = (state_q != ST_IDLE);
    cmd_nibble    = (state_q == ST_DECODE) ? ham_nibble : nibble_q;
    tx_data       = tx_data_q;
    err_count     = err_cnt_q;
  end

endmodule
`default_nettype wire
